regfile_multiport: RTL and testbench

Parametrised successor of the core's fixed 32 x 64-bit register file.
- Generalises data width, register count, read-port count and write-port count.
- Adds registered reads with write-to-read bypass.
- Adds saturating access and bit-toggle counters that feed the power model.
- Sits between decode (read addresses) and writeback (write ports) in the RISC-V datapath.

---
 rtl/regfile_multiport.sv | 162 ++++++++++++++++
 tb/tb_regfile_multiport.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-port register file.
// Reads are registered with one-cycle latency and may forward same-cycle writes.
// Saturating activity counters feed the power model.
module regfile_multiport #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int BYPASS_EN    = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_RD_PORTS-1:0]              rd_en,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  input  logic [NUM_WR_PORTS-1:0]              wr_en,
  input  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]   wr_data,
  input  logic                                 cnt_clr,
  output logic [CNT_WIDTH-1:0]                 rd_access_cnt,
  output logic [CNT_WIDTH-1:0]                 wr_access_cnt,
  output logic [CNT_WIDTH-1:0]                 wr_toggle_cnt
);

  // Wide enough to hold a counter plus the largest per-cycle increment without overflow.
  localparam int SUM_W = CNT_WIDTH + $clog2(NUM_WR_PORTS*DATA_WIDTH + NUM_RD_PORTS + 1) + 1;

  logic [DATA_WIDTH-1:0]           mem_r [NUM_REGS];
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_r;
  logic [CNT_WIDTH-1:0]            rd_cnt_r;
  logic [CNT_WIDTH-1:0]            wr_cnt_r;
  logic [CNT_WIDTH-1:0]            tog_cnt_r;

  logic [NUM_WR_PORTS-1:0]         commit_s;
  logic [DATA_WIDTH-1:0]           rd_next_s [NUM_RD_PORTS];
  logic [SUM_W-1:0]                rd_inc_s;
  logic [SUM_W-1:0]                wr_inc_s;
  logic [SUM_W-1:0]                tog_inc_s;

  // Register 0 and anything past the last register are not backed by storage.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != {ADDR_WIDTH{1'b0}}) && (32'(a) < NUM_REGS);
  endfunction

  function automatic logic [SUM_W-1:0] popcnt(input logic [DATA_WIDTH-1:0] v);
    logic [SUM_W-1:0] c;
    c = {SUM_W{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      c = c + {{(SUM_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = {{(SUM_W-CNT_WIDTH){1'b0}}, cnt} + inc;
    if (|s[SUM_W-1:CNT_WIDTH]) begin
      return {CNT_WIDTH{1'b1}};
    end else begin
      return s[CNT_WIDTH-1:0];
    end
  endfunction

  // Decide which write ports commit: valid address, and not beaten by a higher port on the same address.
  always_comb begin
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      commit_s[w] = wr_en[w] & addr_ok(wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]);
      for (int v = w + 1; v < NUM_WR_PORTS; v++) begin
        commit_s[w] = commit_s[w] &
                      ~(wr_en[v] & (wr_addr[v*ADDR_WIDTH +: ADDR_WIDTH] ==
                                    wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]));
      end
    end
  end

  // Next read value per lane: storage, optionally overridden by a committing write (highest port last).
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_next_s[p] = {DATA_WIDTH{1'b0}};
      if (addr_ok(rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
        rd_next_s[p] = mem_r[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
          rd_next_s[p] = ((BYPASS_EN != 0) && commit_s[w] &&
                          (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]))
                         ? wr_data[w*DATA_WIDTH +: DATA_WIDTH] : rd_next_s[p];
        end
      end else begin
        rd_next_s[p] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Per-cycle activity increments: accepted reads, committed writes and flipped storage bits.
  always_comb begin
    rd_inc_s  = {SUM_W{1'b0}};
    wr_inc_s  = {SUM_W{1'b0}};
    tog_inc_s = {SUM_W{1'b0}};
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_inc_s = rd_inc_s + {{(SUM_W-1){1'b0}}, rd_en[p]};
    end
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      wr_inc_s  = wr_inc_s + {{(SUM_W-1){1'b0}}, commit_s[w]};
      tog_inc_s = tog_inc_s + (commit_s[w]
                  ? popcnt(mem_r[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] ^ wr_data[w*DATA_WIDTH +: DATA_WIDTH])
                  : {SUM_W{1'b0}});
    end
  end

  // Register storage; only resolved winners write, so no two ports hit the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_r[r] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (commit_s[w]) begin
          mem_r[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Registered read lanes; a disabled lane keeps its value to avoid toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {(NUM_RD_PORTS*DATA_WIDTH){1'b0}};
    end else begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (rd_en[p]) begin
          rd_data_r[p*DATA_WIDTH +: DATA_WIDTH] <= rd_next_s[p];
        end
      end
    end
  end

  // Saturating activity counters; clear has priority over any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_r  <= {CNT_WIDTH{1'b0}};
      wr_cnt_r  <= {CNT_WIDTH{1'b0}};
      tog_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (cnt_clr) begin
      rd_cnt_r  <= {CNT_WIDTH{1'b0}};
      wr_cnt_r  <= {CNT_WIDTH{1'b0}};
      tog_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      rd_cnt_r  <= sat_add(rd_cnt_r, rd_inc_s);
      wr_cnt_r  <= sat_add(wr_cnt_r, wr_inc_s);
      tog_cnt_r <= sat_add(tog_cnt_r, tog_inc_s);
    end
  end

  assign rd_data       = rd_data_r;
  assign rd_access_cnt = rd_cnt_r;
  assign wr_access_cnt = wr_cnt_r;
  assign wr_toggle_cnt = tog_cnt_r;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed bench with two configurations of the register file.
// u0: defaults (1 write port, bypass on, 32-bit counters).
// u1: 20 registers, 2 write ports, bypass off, 4-bit counters.
module tb_regfile_multiport;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   d0_rd_en;
  logic [9:0]   d0_rd_addr;
  logic [127:0] d0_rd_data;
  logic [0:0]   d0_wr_en;
  logic [4:0]   d0_wr_addr;
  logic [63:0]  d0_wr_data;
  logic         d0_clr;
  logic [31:0]  d0_rdc, d0_wrc, d0_tgc;

  logic [1:0]   d1_rd_en;
  logic [9:0]   d1_rd_addr;
  logic [127:0] d1_rd_data;
  logic [1:0]   d1_wr_en;
  logic [9:0]   d1_wr_addr;
  logic [127:0] d1_wr_data;
  logic         d1_clr;
  logic [3:0]   d1_rdc, d1_wrc, d1_tgc;

  regfile_multiport u0 (
    .clk(clk), .rst_n(rst_n),
    .rd_en(d0_rd_en), .rd_addr(d0_rd_addr), .rd_data(d0_rd_data),
    .wr_en(d0_wr_en), .wr_addr(d0_wr_addr), .wr_data(d0_wr_data),
    .cnt_clr(d0_clr),
    .rd_access_cnt(d0_rdc), .wr_access_cnt(d0_wrc), .wr_toggle_cnt(d0_tgc)
  );

  regfile_multiport #(
    .NUM_REGS(20), .NUM_WR_PORTS(2), .BYPASS_EN(0), .CNT_WIDTH(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .rd_en(d1_rd_en), .rd_addr(d1_rd_addr), .rd_data(d1_rd_data),
    .wr_en(d1_wr_en), .wr_addr(d1_wr_addr), .wr_data(d1_wr_data),
    .cnt_clr(d1_clr),
    .rd_access_cnt(d1_rdc), .wr_access_cnt(d1_wrc), .wr_toggle_cnt(d1_tgc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [63:0] e0, e1;
    logic [31:0] erd, ewr, etg;
  } vec_t;

  vec_t tbl [8];

  // Drive one cycle on u0 (u1 untouched) and sample just after the edge.
  task automatic c0(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                    input logic we, input logic [4:0] wa, input logic [63:0] wd);
    @(negedge clk);
    d0_rd_en = re; d0_rd_addr = {a1, a0};
    d0_wr_en = we; d0_wr_addr = wa; d0_wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on u1 (u0 idled) and sample just after the edge.
  task automatic c1(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                    input logic [1:0] we, input logic [4:0] w0, input logic [63:0] v0,
                    input logic [4:0] w1, input logic [63:0] v1, input logic clr);
    @(negedge clk);
    d0_rd_en = 2'b00; d0_wr_en = 1'b0;
    d1_rd_en = re; d1_rd_addr = {a1, a0};
    d1_wr_en = we; d1_wr_addr = {w1, w0}; d1_wr_data = {v1, v0};
    d1_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                      input logic [3:0] erd, input logic [3:0] ewr, input logic [3:0] etg);
    chk({tag, " u1 lane0"}, d1_rd_data[63:0], e0);
    chk({tag, " u1 lane1"}, d1_rd_data[127:64], e1);
    chk({tag, " u1 rd_cnt"}, 64'(d1_rdc), 64'(erd));
    chk({tag, " u1 wr_cnt"}, 64'(d1_wrc), 64'(ewr));
    chk({tag, " u1 tog_cnt"}, 64'(d1_tgc), 64'(etg));
  endtask

  initial begin
    // Table for u0 after the initial 32-cycle read sweep (rd=64, wr=0, tog=0).
    //          re     ra0    ra1    we    wa     wd                      e0                      e1                      erd  ewr tog
    tbl[0] = '{2'b00, 5'd0,  5'd0,  1'b1, 5'd5,  64'hFFFF_0000_0000_00FF, 64'h0,                  64'h0,                  64,  1,  24};
    tbl[1] = '{2'b11, 5'd5,  5'd5,  1'b0, 5'd0,  64'h0,                  64'hFFFF_0000_0000_00FF, 64'hFFFF_0000_0000_00FF, 66,  1,  24};
    tbl[2] = '{2'b11, 5'd5,  5'd7,  1'b1, 5'd7,  64'hA5,                 64'hFFFF_0000_0000_00FF, 64'hA5,                 68,  2,  28};
    tbl[3] = '{2'b01, 5'd0,  5'd0,  1'b1, 5'd0,  64'h1234,               64'h0,                  64'hA5,                 69,  2,  28};
    tbl[4] = '{2'b10, 5'd5,  5'd7,  1'b0, 5'd0,  64'h0,                  64'h0,                  64'hA5,                 70,  2,  28};
    tbl[5] = '{2'b11, 5'd5,  5'd5,  1'b1, 5'd5,  64'h0F00_0000_0000_00FF, 64'h0F00_0000_0000_00FF, 64'h0F00_0000_0000_00FF, 72,  3,  40};
    tbl[6] = '{2'b11, 5'd31, 5'd5,  1'b1, 5'd31, 64'h1,                  64'h1,                  64'h0F00_0000_0000_00FF, 74,  4,  41};
    tbl[7] = '{2'b11, 5'd7,  5'd31, 1'b0, 5'd0,  64'h0,                  64'hA5,                 64'h1,                  76,  4,  41};

    d0_rd_en = 2'b00; d0_rd_addr = 10'd0; d0_wr_en = 1'b0; d0_wr_addr = 5'd0;
    d0_wr_data = 64'h0; d0_clr = 1'b0;
    d1_rd_en = 2'b00; d1_rd_addr = 10'd0; d1_wr_en = 2'b00; d1_wr_addr = 10'd0;
    d1_wr_data = 128'h0; d1_clr = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset u0 rd_data", d0_rd_data[63:0] | d0_rd_data[127:64], 64'h0);
    chk("reset u0 rd_cnt", 64'(d0_rdc), 64'h0);
    chk("reset u1 tog_cnt", 64'(d1_tgc), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read x0..x31 on both ports of u0: all zero, 64 accesses counted.
    for (int i = 0; i < 32; i++) begin
      c0(2'b11, 5'(i), 5'(i), 1'b0, 5'd0, 64'h0);
      chk("sweep lanes", d0_rd_data[63:0] | d0_rd_data[127:64], 64'h0);
    end
    chk("sweep rd_cnt", 64'(d0_rdc), 64'd64);
    chk("sweep wr_cnt", 64'(d0_wrc), 64'd0);

    // Table-driven u0 vectors.
    for (int k = 0; k < 8; k++) begin
      c0(tbl[k].re, tbl[k].ra0, tbl[k].ra1, tbl[k].we, tbl[k].wa, tbl[k].wd);
      chk($sformatf("vec%0d lane0", k), d0_rd_data[63:0], tbl[k].e0);
      chk($sformatf("vec%0d lane1", k), d0_rd_data[127:64], tbl[k].e1);
      chk($sformatf("vec%0d rd_cnt", k), 64'(d0_rdc), 64'(tbl[k].erd));
      chk($sformatf("vec%0d wr_cnt", k), 64'(d0_wrc), 64'(tbl[k].ewr));
      chk($sformatf("vec%0d tog_cnt", k), 64'(d0_tgc), 64'(tbl[k].etg));
    end

    // u1: both ports write x3, port1 reads x3 same cycle (no bypass -> old 0).
    c1(2'b10, 5'd0, 5'd3, 2'b11, 5'd3, 64'h11, 5'd3, 64'h22, 1'b0);
    chk1("collide", 64'h0, 64'h0, 4'd1, 4'd1, 4'd2);
    c1(2'b11, 5'd3, 5'd3, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0);
    chk1("x3 read", 64'h22, 64'h22, 4'd3, 4'd1, 4'd2);
    // Write x7, read x7 same cycle: pre-write contents; lane0 holds.
    c1(2'b10, 5'd0, 5'd7, 2'b01, 5'd7, 64'hA5, 5'd0, 64'h0, 1'b0);
    chk1("nobypass", 64'h22, 64'h0, 4'd4, 4'd2, 4'd6);
    c1(2'b01, 5'd7, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0);
    chk1("x7 read", 64'hA5, 64'h0, 4'd5, 4'd2, 4'd6);
    // Out-of-range write x25 dropped; last valid x19 commits.
    c1(2'b01, 5'd25, 5'd0, 2'b11, 5'd19, 64'h3, 5'd25, 64'hFF, 1'b0);
    chk1("range wr", 64'h0, 64'h0, 4'd6, 4'd3, 4'd8);
    c1(2'b10, 5'd0, 5'd19, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0);
    chk1("x19 read", 64'h0, 64'h3, 4'd7, 4'd3, 4'd8);
    // Two writes to different addresses push toggle count past saturation.
    c1(2'b00, 5'd0, 5'd0, 2'b11, 5'd1, 64'hF, 5'd2, 64'hF0, 1'b0);
    chk1("tog sat", 64'h0, 64'h3, 4'd7, 4'd5, 4'd15);
    // 20 reads: reach exactly 15 after 4 cycles, then stay there.
    for (int i = 0; i < 10; i++) begin
      c1(2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0);
      if (i == 3) chk("rd_cnt at max", 64'(d1_rdc), 64'd15);
    end
    chk1("rd sat", 64'h0, 64'h0, 4'd15, 4'd5, 4'd15);
    // Clear with rd_en=11 and a concurrent write: counters 0, storage still updated.
    c1(2'b11, 5'd3, 5'd4, 2'b01, 5'd4, 64'hFF, 5'd0, 64'h0, 1'b1);
    chk1("clear", 64'h22, 64'h0, 4'd0, 4'd0, 4'd0);
    c1(2'b11, 5'd3, 5'd4, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0);
    chk1("post clr", 64'h22, 64'hFF, 4'd2, 4'd0, 4'd0);

    // Asynchronous reset between edges with a u0 write of x5 in flight.
    @(negedge clk);
    d1_rd_en = 2'b00; d1_wr_en = 2'b00;
    d0_rd_en = 2'b00; d0_wr_en = 1'b1; d0_wr_addr = 5'd5; d0_wr_data = 64'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async u0 lane0", d0_rd_data[63:0], 64'h0);
    chk("async u0 lane1", d0_rd_data[127:64], 64'h0);
    chk("async u0 rd_cnt", 64'(d0_rdc), 64'h0);
    chk("async u0 tog_cnt", 64'(d0_tgc), 64'h0);
    chk("async u1 lane0", d1_rd_data[63:0], 64'h0);
    chk("async u1 rd_cnt", 64'(d1_rdc), 64'h0);
    @(posedge clk);
    @(negedge clk);
    d0_wr_en = 1'b0;
    rst_n = 1'b1;
    c0(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 64'h0);
    chk("post rst x5 p0", d0_rd_data[63:0], 64'h0);
    chk("post rst x5 p1", d0_rd_data[127:64], 64'h0);
    chk("post rst wr_cnt", 64'(d0_wrc), 64'h0);
    chk("post rst rd_cnt", 64'(d0_rdc), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
